obc_da_sequencer: RTL and testbench
===================================

# obc_da_sequencer

Bit-serial control and accumulation engine for the OBC distributed-arithmetic DFT datapath. It accepts one block of 16 two's-complement samples, presents one bit-plane per cycle (LSB first) together with the sign-plane flag `m` to the external 16-input OBC ROM/negate/sum stage, and shift-accumulates the returned partial sums into one full-precision DFT output term. One instance drives one ROM stage, i.e. one output bin (real or imaginary part).

## Interface
Parameters:
- `W`, 16: sample width (two's complement); equals the number of bit-plane cycles
- `ROMW`, 32: width of the ROM-stage partial sum (two's complement)
- `ACCW`, `ROMW+W`: accumulator and result width

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous abort; returns the block to IDLE
- `in_valid`  in  1  sample block valid
- `in_ready`  out  1  block can accept samples
- `in_data`  in  16*W  sample i occupies bits [i*W +: W]
- `plane`  out  16  current bit-plane; `plane[i]` = bit k of sample i
- `m`  out  1  high during the sign-plane cycle (k = W-1)
- `rom_data`  in  ROMW  partial sum returned by the ROM stage for `plane`/`m`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  ACCW  accumulated DFT term
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN (only with `OBC_SEQ_ROMREG_EN`), DONE.
- IDLE: `in_ready`=1. On `in_valid && !flush`, capture all 16 samples into a shift register, clear accumulator, set k=0, go to RUN.
- RUN: `plane[i]` = LSB of shifted sample i; `m` = (k==W-1). Each cycle: acc <= acc + (sign-extend(rom_data) << k); samples shift right by 1; k increments. After k=W-1 go to DONE (or DRAIN).
- DONE: `out_valid`=1, `out_data`=acc held stable until `out_ready`; on `out_ready` go to IDLE.
- `plane`=0 and `m`=0 outside RUN.
- Arithmetic: all additions modulo 2^ACCW; no saturation. Shift amount uses the k of the plane that produced `rom_data`.
- `flush` has priority over every other event in every state: next state IDLE, `out_valid` drops, accumulator cleared, no capture even if `in_valid` is high.
- `in_valid` outside IDLE is ignored (no back-pressure violation since `in_ready`=0).

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `plane`=0, `m`=0, `busy`=0, k=0.
- `rom_data` is sampled in the same cycle `plane` is presented (ROM stage is combinational) unless `OBC_SEQ_ROMREG_EN`.
- Accept at edge 0 -> RUN cycles 1..W -> `out_valid` asserted from cycle W+1.
- Minimum period between accepted blocks: W+2 cycles (with zero-wait `out_ready`).
- `in_ready`, `out_valid`, `busy`, `m`, `plane` are functions of registered state only (no combinational path from inputs).
- Reset asserted mid-RUN: all outputs immediately go to reset values; partial result discarded.

## Configuration
- `OBC_SEQ_ROMREG_EN` defined: `rom_data` is registered before the accumulator; accumulation of plane k occurs one cycle after it is presented, using a delayed copy of k; DRAIN state (1 cycle) follows RUN; `out_valid` from cycle W+2; minimum period W+3.
- Not defined: no input register, no DRAIN, timing as above.

## Test plan
Bench ROM model: `rom_data` = m ? -popcount(plane) : popcount(plane), so `out_data` must equal the signed sum of the 16 samples. W=4 unless stated.
- Reset then idle: `in_ready`=1, `out_valid`=0, `out_data`=0, `plane`=0, `busy`=0 for 10 cycles.
- All samples 4'hF (-1) -> `out_data` = -16, `out_valid` at cycle 5 (6 with macro); `m` high exactly in cycle 4 (RUN cycle k=3).
- Sample i = i-8 -> `out_data` = -8; hold `out_ready`=0 for 7 cycles -> `out_data` stable, `in_ready`=0 throughout.
- Back-to-back blocks with `out_ready`=1 and `in_valid` held high -> accepts every 6 cycles (7 with macro); results 0 then +16 for all-zero then all-1 blocks.
- `flush` in RUN cycle 2 with `in_valid` high -> IDLE next cycle, no `out_valid`, no capture that cycle; next block result correct.
- W=16: samples all 16'h7FFF -> `out_data` = 524272, `out_valid` at cycle 17.

Source files
------------

// File: rtl/obc_da_sequencer.sv
// obc_da_sequencer
// Bit-serial control and accumulation engine for one OBC distributed-arithmetic
// DFT term. A block of 16 two's-complement samples is captured, one bit-plane is
// presented per cycle (LSB first) to an external 16-input OBC ROM/negate/sum
// stage, and the returned partial sums are shift-accumulated into the result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort back to IDLE (highest priority)
//   in_valid   sample block valid            in_ready  block can be accepted
//   in_data    16 samples, sample i at [i*W +: W]
//   plane      current bit-plane, plane[i] = bit k of sample i (0 outside RUN)
//   m          sign-plane flag, high when k == W-1 (0 outside RUN)
//   rom_data   partial sum returned by the ROM stage for plane/m
//   out_valid  result valid                  out_ready downstream accepts result
//   out_data   accumulated DFT term (0 unless out_valid)
//   busy       high in every state except IDLE
//
// Build option: define OBC_SEQ_ROMREG_EN to register rom_data ahead of the
// accumulator. Each plane is then accumulated one cycle after it is presented,
// and a one-cycle DRAIN state after RUN absorbs the last plane.
module obc_da_sequencer #(
  parameter int W    = 16,
  parameter int ROMW = 32,
  parameter int ACCW = ROMW + W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16*W-1:0]   in_data,
  output logic [15:0]       plane,
  output logic              m,
  input  logic [ROMW-1:0]   rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   out_data,
  output logic              busy
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef OBC_SEQ_ROMREG_EN
  localparam logic [1:0] S_AFTER_RUN = S_DRAIN;
`else
  localparam logic [1:0] S_AFTER_RUN = S_DONE;
`endif

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [16*W-1:0]  samples;
  logic [16*W-1:0]  samples_shifted;
  logic [ACCW-1:0]  acc;
  logic [ROMW-1:0]  acc_src;
  logic [KW-1:0]    acc_k;
  logic             acc_en;
  logic [ACCW-1:0]  addend;
  logic             run;
  logic             last_plane;

  assign run        = (state == S_RUN);
  assign last_plane = (k == KW'(W - 1));

  // Each lane shifts right independently so the LSB of lane i is always bit k
  // of sample i.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign plane[gi] = run & samples[gi*W];
      assign samples_shifted[gi*W +: W] = samples[gi*W +: W] >> 1;
    end
  endgenerate

`ifdef OBC_SEQ_ROMREG_EN
  // Delayed copy of the ROM result together with the k of the plane that
  // produced it, so the shift weight matches the data.
  logic [ROMW-1:0] rom_q;
  logic [KW-1:0]   k_q;
  logic            en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_q <= '0;
      k_q   <= '0;
      en_q  <= 1'b0;
    end else if (flush) begin
      en_q  <= 1'b0;
    end else begin
      rom_q <= rom_data;
      k_q   <= k;
      en_q  <= run;
    end
  end

  assign acc_src = rom_q;
  assign acc_k   = k_q;
  assign acc_en  = en_q;
`else
  assign acc_src = rom_data;
  assign acc_k   = k;
  assign acc_en  = run;
`endif

  // Sign-extend to full precision before weighting by 2^k; wraps modulo 2^ACCW.
  assign addend = {{(ACCW-ROMW){acc_src[ROMW-1]}}, acc_src} << acc_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      samples <= '0;
      acc     <= '0;
    end else if (flush) begin
      state   <= S_IDLE;
      k       <= '0;
      acc     <= '0;
    end else begin
      if (acc_en) begin
        acc <= acc + addend;
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            samples <= in_data;
            acc     <= '0;
            k       <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          samples <= samples_shifted;
          if (last_plane) begin
            k     <= '0;
            state <= S_AFTER_RUN;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign m         = run & last_plane;
  assign out_data  = out_valid ? acc : '0;

endmodule

// File: tb/tb_obc_da_sequencer.sv
// Testbench for obc_da_sequencer. A W=4 instance is exercised with directed and
// random traffic against a cycle-level reference model; a W=16 instance covers
// the wide-sample case. The OBC ROM stage is modelled as
// rom_data = m ? -popcount(plane) : popcount(plane), so every result must equal
// the signed sum of the 16 samples of its block.
module tb_obc_da_sequencer;

  localparam int W      = 4;
  localparam int ROMW   = 32;
  localparam int ACCW   = ROMW + W;
  localparam int W16    = 16;
  localparam int ACCW16 = ROMW + W16;
`ifdef OBC_SEQ_ROMREG_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  localparam int LAT   = W + 1 + XTRA;
  localparam int LAT16 = W16 + 1 + XTRA;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [16*W-1:0]   in_data = '0;
  logic [15:0]       plane;
  logic              m;
  logic [ROMW-1:0]   rom_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACCW-1:0]   out_data;
  logic              busy;

  logic              flush16 = 1'b0;
  logic              in_valid16 = 1'b0;
  logic              in_ready16;
  logic [16*W16-1:0] in_data16 = '0;
  logic [15:0]       plane16;
  logic              m16;
  logic [ROMW-1:0]   rom_data16;
  logic              out_valid16;
  logic              out_ready16 = 1'b1;
  logic [ACCW16-1:0] out_data16;
  logic              busy16;

  obc_da_sequencer #(.W(W), .ROMW(ROMW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .plane(plane), .m(m),
    .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  obc_da_sequencer #(.W(W16), .ROMW(ROMW)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush16), .in_valid(in_valid16),
    .in_ready(in_ready16), .in_data(in_data16), .plane(plane16), .m(m16),
    .rom_data(rom_data16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .busy(busy16)
  );

  always #5 clk = ~clk;

  int pc4, pc16;
  always_comb begin
    pc4 = $countones(plane);
    rom_data = m ? ROMW'(-pc4) : ROMW'(pc4);
  end
  always_comb begin
    pc16 = $countones(plane16);
    rom_data16 = m16 ? ROMW'(-pc16) : ROMW'(pc16);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [ACCW-1:0] model_sum(input logic [16*W-1:0] d);
    longint s;
    s = 0;
    for (int i = 0; i < 16; i++) s += longint'($signed(d[i*W +: W]));
    return ACCW'(s);
  endfunction

  // ---------------- reference model (W=4) ----------------
  // A block occupies the engine from its accept edge until its result is
  // taken: RUN in relative cycles 1..W, result valid from relative cycle LAT.
  logic [ACCW-1:0] exp_q[$];
  bit              idle_m = 1'b1;
  int              base = 0;
  int              rel;
  logic [16*W-1:0] cap = '0;
  logic [15:0]     ep;
  bit              run_m, ov_m;
  bit              zero_chk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      idle_m = 1'b1;
      exp_q.delete();
    end else begin
      rel   = cyc - base;
      run_m = !idle_m && rel >= 1 && rel <= W;
      ov_m  = !idle_m && rel >= LAT;
      ep    = '0;
      if (run_m)
        for (int i = 0; i < 16; i++) ep[i] = cap[i*W + rel - 1];
      chk("in_ready", 64'(in_ready), 64'(idle_m));
      chk("busy", 64'(busy), 64'(!idle_m));
      chk("m", 64'(m), 64'(run_m && rel == W));
      chk("plane", 64'(plane), 64'(ep));
      chk("out_valid", 64'(out_valid), 64'(ov_m));
      if (zero_chk) chk("out_data_idle", 64'(out_data), 64'd0);
      if (flush) begin
        if (!idle_m && exp_q.size() > 0) void'(exp_q.pop_back());
        idle_m = 1'b1;
      end else if (idle_m && in_valid) begin
        idle_m = 1'b0;
        base   = cyc;
        cap    = in_data;
        exp_q.push_back(model_sum(in_data));
      end else if (ov_m && out_ready) begin
        idle_m = 1'b1;
      end
    end
  end

  // ---------------- result monitor (W=4) ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 64'(out_valid), 64'd0);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q[0]));
        if (out_ready && !flush) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- result monitor (W=16) ----------------
  logic [ACCW16-1:0] q16[$];
  int base16 = 0;
  always @(negedge clk) begin
    if (rst_n && out_valid16) begin
      if (q16.size() == 0) begin
        chk("w16_unexpected", 64'(out_valid16), 64'd0);
      end else begin
        chk("w16_data", 64'(out_data16), 64'(q16[0]));
        chk("w16_latency", 64'(cyc - base16), 64'(LAT16));
        if (out_ready16) void'(q16.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Holds in_valid high with d until an edge at which in_ready was high.
  task automatic send_block(input logic [16*W-1:0] d);
    bit r;
    bit done;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    done = 1'b0;
    while (!done && n <= 60) begin
      r = in_ready;
      tick();
      n++;
      if (r) done = 1'b1;
    end
    chk("accept_timeout", 64'(done), 64'd1);
  endtask

  function automatic logic [16*W-1:0] fill(input logic [W-1:0] v);
    logic [16*W-1:0] d;
    for (int i = 0; i < 16; i++) d[i*W +: W] = v;
    return d;
  endfunction

  logic [16*W-1:0] ramp;
  int n;

  initial begin
    for (int i = 0; i < 16; i++) ramp[i*W +: W] = W'(i - 8);

    // reset, then idle with reset values
    repeat (3) tick();
    rst_n = 1'b1;
    zero_chk = 1'b1;
    repeat (10) tick();
    zero_chk = 1'b0;

    // all -1 -> -16
    out_ready = 1'b1;
    send_block(fill(4'hF));
    in_valid = 1'b0;
    repeat (LAT + 3) tick();

    // ramp -> -8, result held for several cycles without out_ready
    out_ready = 1'b0;
    send_block(ramp);
    in_valid = 1'b0;
    repeat (LAT + 7) tick();
    out_ready = 1'b1;
    repeat (2) tick();

    // back-to-back blocks with in_valid held high: 0 then +16
    send_block(fill(4'h0));
    send_block(fill(4'h1));
    in_valid = 1'b0;
    repeat (LAT + 4) tick();

    // flush in RUN cycle 2 with in_valid high, then a clean block
    send_block({$urandom, $urandom});
    in_data = {$urandom, $urandom};
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    send_block({$urandom, $urandom});
    in_valid = 1'b0;
    repeat (LAT + 3) tick();

    // asynchronous reset in the middle of RUN
    send_block({$urandom, $urandom});
    in_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_plane", 64'(plane), 64'd0);
    chk("rst_m", 64'(m), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // W=16: all 16'h7FFF -> 524272
    in_data16  = {16{16'h7FFF}};
    in_valid16 = 1'b1;
    base16     = cyc;
    q16.push_back(ACCW16'(524272));
    tick();
    in_valid16 = 1'b0;
    n = 0;
    while (q16.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    chk("w16_done", 64'(q16.size()), 64'd0);

    // randomized traffic
    for (int t = 0; t < 600; t++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end

    // drain
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!(in_ready && exp_q.size() == 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
